multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/riscv_pkg.sv | 73 +++++++
 rtl/multicycle_controller.sv | 217 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared definitions for the multicycle RISC-V control path:
//                FSM state enumeration, major opcodes, datapath mux/ALU
//                select encodings and the immediate-format decode helper.
//  Revision    : 1.0  initial release
// ============================================================================
package riscv_pkg;

    // Numeric values are visible on state_o, so they are fixed explicitly.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10
    } state_t;

    // Major opcodes
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_rtype  = 7'b0110011;
    localparam logic [6:0] c_op_itype  = 7'b0010011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_branch = 7'b1100011;

    // ALU operand A select
    localparam logic [1:0] c_srca_pc    = 2'b00;
    localparam logic [1:0] c_srca_oldpc = 2'b01;
    localparam logic [1:0] c_srca_rs1   = 2'b10;

    // ALU operand B select
    localparam logic [1:0] c_srcb_rs2   = 2'b00;
    localparam logic [1:0] c_srcb_imm   = 2'b01;
    localparam logic [1:0] c_srcb_four  = 2'b10;

    // Result select
    localparam logic [1:0] c_res_aluout    = 2'b00;
    localparam logic [1:0] c_res_data      = 2'b01;
    localparam logic [1:0] c_res_aluresult = 2'b10;

    // ALU operation class
    localparam logic [1:0] c_aluop_add   = 2'b00;
    localparam logic [1:0] c_aluop_sub   = 2'b01;
    localparam logic [1:0] c_aluop_funct = 2'b10;

    // Immediate format select
    localparam logic [1:0] c_imm_i = 2'b00;
    localparam logic [1:0] c_imm_s = 2'b01;
    localparam logic [1:0] c_imm_b = 2'b10;
    localparam logic [1:0] c_imm_j = 2'b11;

    // Immediate format depends only on the opcode, never on the FSM state.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        logic [1:0] r;
        case (op)
            c_op_store:  r = c_imm_s;
            c_op_branch: r = c_imm_b;
            c_op_jal:    r = c_imm_j;
            default:     r = c_imm_i;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_controller
//  Description : Moore-style main control FSM for a multicycle RISC-V core
//                (load, store, R/I ALU, jal, beq/bne). Decodes illegal
//                opcodes back to FETCH with a one-cycle illegal_op pulse.
//  Config      : MEM_WAIT_EN - when defined, FETCH/MEMREAD/MEMWRITE stall
//                on mem_ready and a WAIT_TIMEOUT watchdog raises a sticky
//                mem_err. When undefined, mem_ready is ignored and mem_err=0.
//  Ports       : clk, rst (sync, active-high)
//                opcode[6:0], funct3[2:0], zero, mem_ready  (inputs)
//                PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite,
//                illegal_op, mem_err                         (1-bit outputs)
//                ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc  (2-bit outputs)
//                state_o[3:0]                                (debug state)
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_controller
    import riscv_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       illegal_op,
    output logic       mem_err,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ImmSrc,
    output logic [3:0] state_o
);

    state_t     r_state;
    state_t     w_next;
    logic       w_pcwrite;
    logic       w_memread;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_regwrite;
    logic       w_illegal;
    logic       w_hold;
    logic       w_timeout;
    logic       w_unused;

`ifdef MEM_WAIT_EN
    localparam int c_cnt_w = $clog2(WAIT_TIMEOUT + 1);

    logic [c_cnt_w-1:0] r_wait_cnt;
    logic               r_mem_err;

    // A stall is any memory-facing state whose handshake has not completed.
    assign w_hold = ((r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                     (r_state == S_MEMWRITE)) && !mem_ready;
    // The current cycle is the WAIT_TIMEOUT-th consecutive wait cycle.
    assign w_timeout = w_hold && (r_wait_cnt == c_cnt_w'(WAIT_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else if (w_timeout) begin
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b1;
        end else if (w_hold) begin
            r_wait_cnt <= r_wait_cnt + c_cnt_w'(1);
        end else begin
            r_wait_cnt <= '0;
        end
    end

    assign mem_err  = r_mem_err;
    assign w_unused = ^funct3[2:1];
`else
    assign w_hold    = 1'b0;
    assign w_timeout = 1'b0;
    assign mem_err   = 1'b0;
    assign w_unused  = ^{funct3[2:1], mem_ready, 32'(WAIT_TIMEOUT)};
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-state control decode
    always_comb begin
        w_next     = r_state;
        w_pcwrite  = 1'b0;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        w_illegal  = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = c_res_aluout;
        ALUSrcA    = c_srca_pc;
        ALUSrcB    = c_srcb_rs2;
        ALUOp      = c_aluop_add;

        case (r_state)
            S_FETCH: begin
                w_memread = 1'b1;
                w_irwrite = 1'b1;
                w_pcwrite = 1'b1;
                ALUSrcA   = c_srca_pc;
                ALUSrcB   = c_srcb_four;
                ResultSrc = c_res_aluresult;
                w_next    = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = c_srca_oldpc;
                ALUSrcB = c_srcb_imm;
                case (opcode)
                    c_op_load,
                    c_op_store:  w_next = S_MEMADR;
                    c_op_rtype:  w_next = S_EXECUTER;
                    c_op_itype:  w_next = S_EXECUTEI;
                    c_op_jal:    w_next = S_JAL;
                    c_op_branch: w_next = S_BRANCH;
                    default: begin
                        w_illegal = 1'b1;
                        w_next    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = c_srca_rs1;
                ALUSrcB = c_srcb_imm;
                w_next  = (opcode == c_op_load) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc    = 1'b1;
                w_memread = 1'b1;
                w_next    = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = c_res_data;
                w_regwrite = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                w_memwrite = 1'b1;
                w_next     = S_FETCH;
            end
            S_EXECUTER: begin
                ALUSrcA = c_srca_rs1;
                ALUSrcB = c_srcb_rs2;
                ALUOp   = c_aluop_funct;
                w_next  = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA = c_srca_rs1;
                ALUSrcB = c_srcb_imm;
                ALUOp   = c_aluop_funct;
                w_next  = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                w_next     = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA   = c_srca_oldpc;
                ALUSrcB   = c_srcb_four;
                w_pcwrite = 1'b1;
                w_next    = S_ALUWB;
            end
            S_BRANCH: begin
                ALUSrcA   = c_srca_rs1;
                ALUSrcB   = c_srcb_rs2;
                ALUOp     = c_aluop_sub;
                // funct3[0] distinguishes bne (taken on !zero) from beq.
                w_pcwrite = zero ^ funct3[0];
                w_next    = S_FETCH;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase

        // While stalled, the memory strobe stays up but PC/IR updates wait
        // for the handshake; a watchdog expiry abandons the instruction.
        if (w_hold) begin
            w_pcwrite = 1'b0;
            w_irwrite = 1'b0;
            w_next    = w_timeout ? S_FETCH : r_state;
        end
    end

    // Strobes are suppressed during reset so FETCH cannot write while held.
    assign PCWrite    = w_pcwrite  & ~rst;
    assign MemRead    = w_memread  & ~rst;
    assign MemWrite   = w_memwrite & ~rst;
    assign IRWrite    = w_irwrite  & ~rst;
    assign RegWrite   = w_regwrite & ~rst;
    assign illegal_op = w_illegal  & ~rst;
    assign ImmSrc     = imm_src_of(opcode);
    assign state_o    = rst ? 4'd0 : 4'(r_state);

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_controller
//  Description : Self-checking bench for multicycle_controller. Each
//                instruction is expanded into its state sequence by opcode
//                class; per-state outputs come from the state output table.
//                Compile with MEM_WAIT_EN defined to exercise stalls/timeout.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite;
    logic       illegal_op, mem_err;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic [3:0] state_o;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       pcw, adr, mr, mw, irw, rw, ill;
        logic [1:0] res, sa, sb, aop, imm;
    } outs_t;

    typedef int iq_t[$];

    outs_t w_obs;
    assign w_obs = {PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite,
                    illegal_op, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc};

    always #5 clk = ~clk;

    multicycle_controller #(.WAIT_TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct3     (funct3),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .illegal_op (illegal_op),
        .mem_err    (mem_err),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .ImmSrc     (ImmSrc),
        .state_o    (state_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // State sequence of one instruction, FETCH included; its length is the
    // instruction latency (load 5, store 4, ALU/jal 4, branch 3, illegal 2).
    function automatic iq_t seq_for(input logic [6:0] op);
        iq_t q;
        case (op)
            7'b0000011: q = '{0, 1, 2, 3, 4};
            7'b0100011: q = '{0, 1, 2, 5};
            7'b0110011: q = '{0, 1, 6, 7};
            7'b0010011: q = '{0, 1, 8, 7};
            7'b1101111: q = '{0, 1, 9, 7};
            7'b1100011: q = '{0, 1, 10};
            default:    q = '{0, 1};
        endcase
        return q;
    endfunction

    function automatic outs_t expect_out(input int st, input logic [6:0] op,
                                         input logic [2:0] f3, input logic z,
                                         input logic rdy);
        outs_t e = '0;
        case (op)
            7'b0100011: e.imm = 2'd1;
            7'b1100011: e.imm = 2'd2;
            7'b1101111: e.imm = 2'd3;
            default:    e.imm = 2'd0;
        endcase
        case (st)
            0:  begin e.mr = 1; e.irw = 1; e.sb = 2; e.res = 2; e.pcw = 1; end
            1:  begin
                    e.sa = 1; e.sb = 1;
                    e.ill = !(op inside {7'b0000011, 7'b0100011, 7'b0110011,
                                         7'b0010011, 7'b1101111, 7'b1100011});
                end
            2:  begin e.sa = 2; e.sb = 1; end
            3:  begin e.adr = 1; e.mr = 1; end
            4:  begin e.res = 1; e.rw = 1; end
            5:  begin e.adr = 1; e.mw = 1; end
            6:  begin e.sa = 2; e.aop = 2; end
            7:  begin e.rw = 1; end
            8:  begin e.sa = 2; e.sb = 1; e.aop = 2; end
            9:  begin e.sa = 1; e.sb = 2; e.pcw = 1; end
            10: begin e.sa = 2; e.aop = 1; e.pcw = z ^ f3[0]; end
            default: e = '0;
        endcase
`ifdef MEM_WAIT_EN
        if (st == 0 && !rdy) begin e.pcw = 0; e.irw = 0; end
`else
        if (rdy === 1'bx) e = '0;
`endif
        return e;
    endfunction

    // Runs one whole instruction starting in FETCH at posedge+1.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic z, input bit waits);
        iq_t   s;
        outs_t e;
        s = seq_for(op);
        foreach (s[k]) begin
            int nw;
            nw = 0;
`ifdef MEM_WAIT_EN
            if (waits && (s[k] == 0 || s[k] == 3 || s[k] == 5))
                nw = int'($urandom_range(0, 4));
`else
            if (waits) nw = 0;
`endif
            for (int w = 0; w <= nw; w++) begin
                opcode = op; funct3 = f3; zero = z;
`ifdef MEM_WAIT_EN
                mem_ready = (w == nw);
`else
                mem_ready = 1'($urandom_range(0, 1));
`endif
                #1;
                e = expect_out(s[k], op, f3, z, mem_ready);
                chk($sformatf("state op=%b step=%0d", op, k), 32'(state_o), 32'(s[k]));
                chk($sformatf("outs op=%b st=%0d", op, s[k]), 32'(w_obs), 32'(e));
                chk("memrd_memwr_excl", 32'(MemRead & MemWrite), 32'd0);
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        logic [6:0] ops [6];
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};

        rst = 1'b1; opcode = 7'd0; funct3 = 3'd0; zero = 1'b0; mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 32'(state_o), 32'd0);
        chk("reset_strobes", 32'({PCWrite, MemRead, MemWrite, IRWrite, RegWrite, illegal_op}), 32'd0);
        chk("reset_mem_err", 32'(mem_err), 32'd0);
        rst = 1'b0;

        // Directed instructions
        run_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
        run_instr(7'b1100011, 3'b000, 1'b1, 1'b0);
        run_instr(7'b1100011, 3'b001, 1'b1, 1'b0);
        run_instr(7'b1100011, 3'b001, 1'b0, 1'b0);
        run_instr(7'b1111111, 3'b000, 1'b0, 1'b0);
        run_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
        run_instr(7'b0110011, 3'b000, 1'b0, 1'b0);
        run_instr(7'b0010011, 3'b000, 1'b0, 1'b0);
        run_instr(7'b1101111, 3'b000, 1'b0, 1'b0);
        chk("no_mem_err_after_directed", 32'(mem_err), 32'd0);

        // Random instruction stream, roughly one in four opcodes arbitrary
        for (int i = 0; i < 60; i++) begin
            logic [6:0] op;
            if ($urandom_range(0, 3) == 0) op = 7'($urandom);
            else                           op = ops[$urandom_range(0, 5)];
            run_instr(op, 3'($urandom), 1'($urandom), 1'b1);
        end

        // Reset while in MEMWRITE
        opcode = 7'b0100011; funct3 = 3'b010; zero = 1'b0; mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_state_memwrite", 32'(state_o), 32'd5);
        chk("pre_rst_memwrite", 32'(MemWrite), 32'd1);
        rst = 1'b1;
        #1;
        chk("in_rst_memwrite_gated", 32'(MemWrite), 32'd0);
        @(posedge clk); #1;
        chk("post_rst_state", 32'(state_o), 32'd0);
        chk("post_rst_memwrite", 32'(MemWrite), 32'd0);
        rst = 1'b0;
        run_instr(7'b0110011, 3'b000, 1'b0, 1'b0);

`ifdef MEM_WAIT_EN
        // Load stalled three cycles in MEMREAD
        opcode = 7'b0000011; mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            #1;
            chk($sformatf("memread_hold_state_%0d", i), 32'(state_o), 32'd3);
            chk($sformatf("memread_hold_rd_%0d", i), 32'(MemRead), 32'd1);
            @(posedge clk); #1;
        end
        chk("after_memread_state", 32'(state_o), 32'd4);
        @(posedge clk); #1;

        // Watchdog expiry in FETCH
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("timeout_pending_%0d", i), 32'(mem_err), 32'd0);
            chk($sformatf("timeout_fetch_hold_%0d", i), 32'(state_o), 32'd0);
            @(posedge clk); #1;
        end
        chk("timeout_mem_err_set", 32'(mem_err), 32'd1);
        chk("timeout_state_fetch", 32'(state_o), 32'd0);
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("mem_err_sticky", 32'(mem_err), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mem_err_cleared_by_rst", 32'(mem_err), 32'd0);
        rst = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
